// File: rtl/sha256d_core_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256d_core_if
// Purpose  : Command, block-transfer and result bundle for sha256d_core.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256d_core_if #(
  parameter int MAX_BLOCKS = 4,
  parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
);
  logic             start;
  logic [CNT_W-1:0] num_blocks;
  logic             double_en;
  logic             abort;
  logic [511:0]     block_data;
  logic             block_valid;
  logic             block_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [255:0]     digest;

  // Front end / host side
  modport master (
    output start, num_blocks, double_en, abort, block_data, block_valid,
    input  block_ready, busy, done, err, digest
  );

  // Hashing engine side
  modport slave (
    input  start, num_blocks, double_en, abort, block_data, block_valid,
    output block_ready, busy, done, err, digest
  );
endinterface
`default_nettype wire

// File: rtl/sha256d_core.sv
`default_nettype none
// ============================================================================
// Module   : sha256d_core
// Purpose  : Multi-block SHA-256 engine, one round per cycle, with optional
//            second internally padded pass for SHA256d.
// Revision : 1.0 - initial release
// ============================================================================
module sha256d_core #(
  parameter int MAX_BLOCKS = 4,
  parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  sha256d_core_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_BLK    = 3'd1,
    S_ROUND       = 3'd2,
    S_UPDATE      = 3'd3,
    S_SECOND_LOAD = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_max_blocks = CNT_W'(MAX_BLOCKS);

  localparam logic [31:0] c_iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] f_bsig0(input logic [31:0] x);
    return f_rotr(x, 2) ^ f_rotr(x, 13) ^ f_rotr(x, 22);
  endfunction

  function automatic logic [31:0] f_bsig1(input logic [31:0] x);
    return f_rotr(x, 6) ^ f_rotr(x, 11) ^ f_rotr(x, 25);
  endfunction

  function automatic logic [31:0] f_ssig0(input logic [31:0] x);
    return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_ssig1(input logic [31:0] x);
    return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t           r_state;
  logic [31:0]      r_hv [8];   // chaining value H0..H7
  logic [31:0]      r_v  [8];   // working variables a..h
  logic [31:0]      r_w  [16];  // schedule window, r_w[0] = W[r]
  logic [5:0]       r_round;
  logic [CNT_W-1:0] r_remain;
  logic             r_double;
  logic             r_pass2;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [255:0]     r_digest;

  logic [31:0]      w_t1;
  logic [31:0]      w_t2;
  logic [31:0]      w_wnew;
  logic [31:0]      w_hsum [8];
  logic [255:0]     w_hcat;

  assign w_t1 = r_v[7] + f_bsig1(r_v[4]) + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]))
              + c_k[r_round] + r_w[0];
  assign w_t2 = f_bsig0(r_v[0]) + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
  // Word 16 positions ahead; computed every round, only consumed while r < 48.
  assign w_wnew = f_ssig1(r_w[14]) + r_w[9] + f_ssig0(r_w[1]) + r_w[0];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
      assign w_hsum[gi]                 = r_hv[gi] + r_v[gi];
      assign w_hcat[255-32*gi -: 32]    = w_hsum[gi];
    end
  endgenerate

  assign bus.block_ready = r_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.digest      = r_digest;

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_hv     <= c_iv;
      for (int i = 0; i < 8; i++)  r_v[i] <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_round  <= '0;
      r_remain <= '0;
      r_double <= 1'b0;
      r_pass2  <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_digest <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (bus.abort) begin
        // Cancel wins over everything; digest is left untouched.
        r_state <= S_IDLE;
        r_ready <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.num_blocks == '0 || bus.num_blocks > c_max_blocks) begin
                r_err <= 1'b1;
              end else begin
                r_remain <= bus.num_blocks;
                r_double <= bus.double_en;
                r_hv     <= c_iv;
                r_pass2  <= 1'b0;
                r_ready  <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= S_WAIT_BLK;
              end
            end
          end
          S_WAIT_BLK: begin
            if (bus.block_valid) begin
              for (int i = 0; i < 16; i++) r_w[i] <= bus.block_data[511-32*i -: 32];
              r_v      <= r_hv;
              r_round  <= '0;
              r_remain <= r_remain - CNT_W'(1);
              r_ready  <= 1'b0;
              r_state  <= S_ROUND;
            end
          end
          S_ROUND: begin
            r_v[0] <= w_t1 + w_t2;
            r_v[1] <= r_v[0];
            r_v[2] <= r_v[1];
            r_v[3] <= r_v[2];
            r_v[4] <= r_v[3] + w_t1;
            r_v[5] <= r_v[4];
            r_v[6] <= r_v[5];
            r_v[7] <= r_v[6];
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_wnew;
            r_round <= r_round + 6'd1;
            if (r_round == 6'd63) r_state <= S_UPDATE;
          end
          S_UPDATE: begin
            r_hv <= w_hsum;
            if (r_remain != '0) begin
              r_ready <= 1'b1;
              r_state <= S_WAIT_BLK;
            end else if (r_double && !r_pass2) begin
              r_state <= S_SECOND_LOAD;
            end else begin
              r_digest <= w_hcat;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_SECOND_LOAD: begin
            // Pad the 256-bit first-pass digest into one 512-bit block.
            for (int i = 0; i < 8; i++) r_w[i] <= r_hv[i];
            r_w[8] <= 32'h80000000;
            for (int i = 9; i < 15; i++) r_w[i] <= '0;
            r_w[15] <= 32'h00000100;
            r_hv    <= c_iv;
            r_v     <= c_iv;
            r_pass2 <= 1'b1;
            r_round <= '0;
            r_state <= S_ROUND;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256d_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256d_core
// Purpose  : Directed self-checking bench for sha256d_core using known
//            SHA-256 / SHA256d vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256d_core;

  localparam int MAX_BLOCKS = 4;

  localparam logic [511:0] c_blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_blk_empty = {32'h80000000, 480'h0};
  localparam logic [511:0] c_blk_two1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_blk_two2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] c_dig_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] c_dig_abcd  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] c_dig_two   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] c_dig_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  sha256d_core_if #(.MAX_BLOCKS(MAX_BLOCKS)) bus ();

  sha256d_core #(.MAX_BLOCKS(MAX_BLOCKS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int nb, input logic dbl, input string tag);
    bus.start      = 1'b1;
    bus.num_blocks = 3'(nb);
    bus.double_en  = dbl;
    tick;
    bus.start      = 1'b0;
    chk({tag, "_ready_after_start"}, 256'(bus.block_ready), 256'd1);
  endtask

  task automatic send_block(input logic [511:0] data, input string tag);
    int n;
    n = 0;
    bus.block_data  = data;
    bus.block_valid = 1'b1;
    while (!bus.block_ready && n < 200) begin
      tick;
      n++;
    end
    chk({tag, "_ready_seen"}, 256'(bus.block_ready), 256'd1);
    tick;
    bus.block_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int exp_n, input string tag);
    int n;
    n = n0;
    while (!bus.done && n < 300) begin
      tick;
      n++;
    end
    chk({tag, "_done_latency"}, 256'(n), 256'(exp_n));
  endtask

  initial begin
    int  n;
    logic ok;
    logic seen;
    checks          = 0;
    errors          = 0;
    n_rst           = 1'b0;
    bus.start       = 1'b0;
    bus.num_blocks  = '0;
    bus.double_en   = 1'b0;
    bus.abort       = 1'b0;
    bus.block_data  = '0;
    bus.block_valid = 1'b0;
    repeat (3) tick;
    chk("rst_busy",   256'(bus.busy),        256'd0);
    chk("rst_ready",  256'(bus.block_ready), 256'd0);
    chk("rst_done",   256'(bus.done),        256'd0);
    chk("rst_err",    256'(bus.err),         256'd0);
    chk("rst_digest", bus.digest,            256'd0);
    n_rst = 1'b1;
    tick;

    // Single-block "abc"
    do_start(1, 1'b0, "abc");
    send_block(c_blk_abc, "abc");
    wait_done(0, 65, "abc");
    chk("abc_digest", bus.digest, c_dig_abc);
    tick;
    chk("abc_done_pulse", 256'(bus.done), 256'd0);
    chk("abc_idle_busy",  256'(bus.busy), 256'd0);

    // Rejected starts: zero blocks, then MAX_BLOCKS+1
    bus.start = 1'b1; bus.num_blocks = 3'd0; bus.double_en = 1'b0;
    tick;
    bus.start = 1'b0;
    chk("rej0_err",  256'(bus.err),  256'd1);
    chk("rej0_busy", 256'(bus.busy), 256'd0);
    tick;
    chk("rej0_err_pulse", 256'(bus.err), 256'd0);
    bus.start = 1'b1; bus.num_blocks = 3'(MAX_BLOCKS + 1);
    tick;
    bus.start = 1'b0;
    chk("rejmax_err",   256'(bus.err),         256'd1);
    chk("rejmax_busy",  256'(bus.busy),        256'd0);
    chk("rejmax_ready", 256'(bus.block_ready), 256'd0);
    tick;

    // Double "abc" with a stray single-mode start during ROUND
    do_start(1, 1'b1, "abcd");
    send_block(c_blk_abc, "abcd");
    repeat (5) tick;
    bus.start = 1'b1; bus.num_blocks = 3'd1; bus.double_en = 1'b0;
    tick;
    bus.start = 1'b0;
    wait_done(6, 131, "abcd");
    chk("abcd_digest", bus.digest, c_dig_abcd);
    tick;

    // Two-block message with a 10-cycle gap before block 2
    do_start(2, 1'b0, "two");
    send_block(c_blk_two1, "two_b1");
    n = 0;
    while (!bus.block_ready && n < 200) begin
      tick;
      n++;
    end
    chk("two_next_ready_latency", 256'(n), 256'd65);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      ok = ok & bus.block_ready & ~bus.done;
    end
    chk("two_ready_held_in_gap", 256'(ok), 256'd1);
    send_block(c_blk_two2, "two_b2");
    wait_done(0, 65, "two");
    chk("two_digest", bus.digest, c_dig_two);
    tick;

    // Abort at round 30 of block 1
    do_start(1, 1'b0, "abort");
    send_block(c_blk_abc, "abort");
    repeat (30) tick;
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    chk("abort_busy",   256'(bus.busy),        256'd0);
    chk("abort_ready",  256'(bus.block_ready), 256'd0);
    chk("abort_digest", bus.digest,            c_dig_two);
    seen = 1'b0;
    for (int i = 0; i < 140; i++) begin
      tick;
      seen = seen | bus.done;
    end
    chk("abort_no_done",     256'(seen), 256'd0);
    chk("abort_digest_hold", bus.digest, c_dig_two);
    do_start(1, 1'b0, "post_abort");
    send_block(c_blk_abc, "post_abort");
    wait_done(0, 65, "post_abort");
    chk("post_abort_digest", bus.digest, c_dig_abc);
    tick;

    // Reset during pass-2 ROUND, then empty message
    do_start(1, 1'b1, "rstp2");
    send_block(c_blk_abc, "rstp2");
    repeat (80) tick;
    chk("rstp2_busy_before", 256'(bus.busy), 256'd1);
    n_rst = 1'b0;
    #2;
    chk("rstp2_busy",   256'(bus.busy),        256'd0);
    chk("rstp2_ready",  256'(bus.block_ready), 256'd0);
    chk("rstp2_done",   256'(bus.done),        256'd0);
    chk("rstp2_err",    256'(bus.err),         256'd0);
    chk("rstp2_digest", bus.digest,            256'd0);
    tick;
    tick;
    n_rst = 1'b1;
    tick;
    tick;
    chk("rstp2_ready_after_release", 256'(bus.block_ready), 256'd0);
    do_start(1, 1'b0, "empty");
    send_block(c_blk_empty, "empty");
    wait_done(0, 65, "empty");
    chk("empty_digest", bus.digest, c_dig_empty);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
